// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared state encoding and default sizes for the SPI register controller
package spi_reg_pkg;

  localparam int SPI_ADDRSZ  = 7;
  localparam int SPI_PAYLOAD = 8;
  localparam int SPI_NREGS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_FETCH,
    ST_RD_HOLD,
    ST_WR_WAIT,
    ST_WR_COMMIT,
    ST_DRAIN
  } spi_reg_state_t;

endpackage

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - single-port flop register bank with registered read and out-of-range flag
module reg_bank
  import spi_reg_pkg::*;
#(
  parameter int addrsz  = SPI_ADDRSZ,
  parameter int payload = SPI_PAYLOAD,
  parameter int nregs   = SPI_NREGS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [addrsz-1:0]  addr,
  input  logic [payload-1:0] wdata,
  output logic [payload-1:0] rdata,
  output logic               oob
);

  localparam int IDXW = (nregs > 1) ? $clog2(nregs) : 1;

  logic [payload-1:0] r_mem [nregs];
  logic [IDXW-1:0]    w_idx;

  // Compare on the full address width so high addresses never alias into the bank.
  assign oob   = ({1'b0, addr} >= (addrsz + 1)'(nregs));
  assign w_idx = addr[IDXW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < nregs; i++) begin
        r_mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we && !oob) begin
        r_mem[w_idx] <= wdata;
      end
      rdata <= oob ? '0 : r_mem[w_idx];
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - sequences spi_slave transactions into a register bank shared with a core port
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int addrsz  = SPI_ADDRSZ,
  parameter int payload = SPI_PAYLOAD,
  parameter int nregs   = SPI_NREGS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [addrsz-1:0]  spi_addr,
  input  logic               spi_addr_dv,
  input  logic               spi_rw,
  input  logic [payload-1:0] spi_rx_d,
  input  logic               spi_rxdv,
  output logic [payload-1:0] spi_tx_d,
  output logic               spi_tx_en,
  input  logic               core_req,
  input  logic               core_we,
  input  logic [addrsz-1:0]  core_addr,
  input  logic [payload-1:0] core_wdata,
  output logic               core_gnt,
  output logic               core_rvalid,
  output logic [payload-1:0] core_rdata,
  output logic               spi_wr_pulse,
  output logic               spi_err,
  output logic               busy
);

  spi_reg_state_t     r_state, w_next;
  logic               r_dv_q, r_rxdv_q;
  logic [addrsz-1:0]  r_addr_q;
  logic               r_tx_first;
  logic [payload-1:0] r_tx_d;
  logic               r_core_rvalid;

  logic               w_dv_re, w_dv_fe, w_rxdv_re;
  logic               w_spi_owns, w_core_gnt;
  logic               w_bank_we, w_oob;
  logic [addrsz-1:0]  w_bank_addr;
  logic [payload-1:0] w_bank_wdata, w_bank_rdata;
  logic               w_tx_en, w_busy, w_wr_pulse, w_err;

  assign w_dv_re   = spi_addr_dv & ~r_dv_q;
  assign w_dv_fe   = ~spi_addr_dv & r_dv_q;
  assign w_rxdv_re = spi_rxdv & ~r_rxdv_q;

  assign w_spi_owns   = (r_state == ST_RD_FETCH) || (r_state == ST_WR_COMMIT);
  assign w_core_gnt   = core_req & ~w_spi_owns & ~reset;
  assign w_bank_addr  = w_spi_owns ? r_addr_q : core_addr;
  assign w_bank_we    = (r_state == ST_WR_COMMIT) | (w_core_gnt & core_we);
  assign w_bank_wdata = (r_state == ST_WR_COMMIT) ? spi_rx_d : core_wdata;

  reg_bank #(
    .addrsz (addrsz),
    .payload(payload),
    .nregs  (nregs)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .we   (w_bank_we),
    .addr (w_bank_addr),
    .wdata(w_bank_wdata),
    .rdata(w_bank_rdata),
    .oob  (w_oob)
  );

  always_comb begin
    w_next     = r_state;
    w_tx_en    = 1'b0;
    w_busy     = (r_state != ST_IDLE);
    w_wr_pulse = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dv_re) w_next = spi_rw ? ST_RD_FETCH : ST_WR_WAIT;
      end
      ST_RD_FETCH: begin
        w_err  = w_oob;
        w_next = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        w_tx_en = 1'b1;
        if (w_dv_fe) w_next = ST_IDLE;
      end
      ST_WR_WAIT: begin
        // A data strobe arriving with the closing edge still commits.
        if (w_rxdv_re)    w_next = ST_WR_COMMIT;
        else if (w_dv_fe) w_next = ST_IDLE;
      end
      ST_WR_COMMIT: begin
        w_wr_pulse = ~w_oob;
        w_err      = w_oob;
        w_next     = spi_addr_dv ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (w_dv_fe) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_dv_q        <= 1'b0;
      r_rxdv_q      <= 1'b0;
      r_addr_q      <= '0;
      r_tx_first    <= 1'b0;
      r_tx_d        <= '0;
      r_core_rvalid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_dv_q        <= spi_addr_dv;
      r_rxdv_q      <= spi_rxdv;
      if (r_state == ST_IDLE && w_dv_re) r_addr_q <= spi_addr;
      r_tx_first    <= (r_state == ST_RD_FETCH);
      if (r_tx_first) r_tx_d <= w_bank_rdata;
      r_core_rvalid <= w_core_gnt & ~core_we;
    end
  end

  // The fetched value sits in the bank read register for one cycle only; latch it so
  // core reads during RD_HOLD cannot disturb what the slave samples.
  assign spi_tx_d     = reset ? '0 : (r_tx_first ? w_bank_rdata : r_tx_d);
  assign spi_tx_en    = w_tx_en & ~reset;
  assign core_gnt     = w_core_gnt;
  assign core_rvalid  = r_core_rvalid & ~reset;
  assign core_rdata   = reset ? '0 : w_bank_rdata;
  assign spi_wr_pulse = w_wr_pulse & ~reset;
  assign spi_err      = w_err & ~reset;
  assign busy         = w_busy & ~reset;

endmodule
